// File: rtl/seq_magnitude_comparator.sv
// seq_magnitude_comparator: multi-cycle WIDTH-bit magnitude comparator.
// Compares A and B MSB-first, CHUNK bits per cycle, signed or unsigned per transaction.
// Operands enter on a valid/ready handshake; g/l/e leave on a valid/ready handshake.
// Optional build macro: CMP_EARLY_EXIT_EN. When defined, RUN ends on the first differing
// chunk instead of always running all NCHUNK chunks.
module seq_magnitude_comparator #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             signed_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             g,
    output logic             l,
    output logic             e,
    output logic             busy
);

    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned IdxW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NCHUNK - 1);

    // Reject configurations the chunked datapath cannot handle.
    if (WIDTH < 2 || CHUNK == 0 || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
        $error("seq_magnitude_comparator: WIDTH must be >= 2 and a multiple of CHUNK");
    end

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic              decided_q, decided_d;
    logic              gt_q, gt_d;

    // The operand registers shift left each RUN cycle, so the chunk under test
    // always sits at the top and no wide index mux is needed.
    logic [CHUNK-1:0]  chunk_a;
    logic [CHUNK-1:0]  chunk_b;
    logic              chunk_diff;
    logic              chunk_gt;
    logic              run_last;

    assign chunk_a    = a_q[WIDTH-1 -: CHUNK];
    assign chunk_b    = b_q[WIDTH-1 -: CHUNK];
    assign chunk_diff = (chunk_a != chunk_b);
    assign chunk_gt   = (chunk_a > chunk_b);

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            a_q       <= '0;
            b_q       <= '0;
            idx_q     <= '0;
            decided_q <= 1'b0;
            gt_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            idx_q     <= idx_d;
            decided_q <= decided_d;
            gt_q      <= gt_d;
        end
    end

    // Next-state logic: accept, chunk-by-chunk compare, result hold.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        idx_d     = idx_q;
        decided_d = decided_q;
        gt_d      = gt_q;
        run_last  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    // Flipping both MSBs maps two's complement onto offset binary,
                    // so the rest of the compare is purely unsigned.
                    a_d       = A ^ {signed_mode, {(WIDTH-1){1'b0}}};
                    b_d       = B ^ {signed_mode, {(WIDTH-1){1'b0}}};
                    idx_d     = LastIdx;
                    decided_d = 1'b0;
                    gt_d      = 1'b0;
                    state_d   = StRun;
                end
            end
            StRun: begin
                // First differing chunk from the MSB decides; later chunks are ignored.
                if (!decided_q && chunk_diff) begin
                    decided_d = 1'b1;
                    gt_d      = chunk_gt;
                end
                a_d      = a_q << CHUNK;
                b_d      = b_q << CHUNK;
                idx_d    = idx_q - 1'b1;
                run_last = (idx_q == '0);
`ifdef CMP_EARLY_EXIT_EN
                run_last = run_last || (!decided_q && chunk_diff);
`endif
                if (run_last) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs: g/l/e only ever asserted alongside out_valid; undecided means equal.
    always_comb begin
        in_ready  = (state_q == StIdle);
        out_valid = (state_q == StDone);
        busy      = (state_q != StIdle);
        g         = out_valid && decided_q && gt_q;
        l         = out_valid && decided_q && !gt_q;
        e         = out_valid && !decided_q;
    end

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Self-checking bench for seq_magnitude_comparator (16/4 main instance, 12/3 side instance).
module tb_seq_magnitude_comparator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        in_valid, in_ready, signed_mode, out_valid, out_ready, g, l, e, busy;
    logic [15:0] A, B;

    logic        in_valid12, in_ready12, sm12, out_valid12, out_ready12, g12, l12, e12, busy12;
    logic [11:0] A12, B12;

    int checks = 0;
    int errors = 0;

    seq_magnitude_comparator #(.WIDTH(16), .CHUNK(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .A(A), .B(B),
        .signed_mode(signed_mode), .out_valid(out_valid), .out_ready(out_ready),
        .g(g), .l(l), .e(e), .busy(busy)
    );

    seq_magnitude_comparator #(.WIDTH(12), .CHUNK(3)) dut12 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid12), .in_ready(in_ready12), .A(A12),
        .B(B12), .signed_mode(sm12), .out_valid(out_valid12), .out_ready(out_ready12),
        .g(g12), .l(l12), .e(e12), .busy(busy12)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference result: compare the operands as plain integers.
    function automatic logic [2:0] ref_gle(input logic [15:0] a, input logic [15:0] b,
                                           input logic s);
        longint va, vb;
        va = s ? longint'($signed(a)) : longint'(a);
        vb = s ? longint'($signed(b)) : longint'(b);
        if (va > vb) return 3'b100;
        if (va < vb) return 3'b010;
        return 3'b001;
    endfunction

    // Reference latency: 4 chunks, or (early exit) chunk of the highest differing bit + 1.
    function automatic int ref_lat(input logic [15:0] a, input logic [15:0] b);
`ifdef CMP_EARLY_EXIT_EN
        logic [15:0] x;
        x = a ^ b;
        for (int p = 15; p >= 0; p--) begin
            if (x[p]) return (15 - p) / 4 + 1;
        end
        return 4;
`else
        return (a == b) ? 4 : 4;
`endif
    endfunction

    // Transaction-level model of the 16-bit instance: 0 idle, 1 computing, 2 result held.
    int          m_phase = 0;
    int          m_cnt   = 0;
    logic [2:0]  m_gle   = 3'b000;
    bit          chk_en  = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_phase <= 0;
        end else begin
            case (m_phase)
                0: if (in_valid) begin
                    m_gle   <= ref_gle(A, B, signed_mode);
                    m_cnt   <= ref_lat(A, B);
                    m_phase <= 1;
                end
                1: begin
                    m_cnt <= m_cnt - 1;
                    if (m_cnt == 1) m_phase <= 2;
                end
                default: if (out_ready) m_phase <= 0;
            endcase
        end
    end

    // Compare every cycle, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("cycle_outputs", {26'd0, in_ready, out_valid, busy, g, l, e},
                  {26'd0, m_phase == 0, m_phase == 2, m_phase != 0,
                   (m_phase == 2) ? m_gle : 3'b000});
        end
    end

    task automatic wait_ready16();
        int n = 0;
        while (!in_ready && n < 64) begin
            @(posedge clk); #1; n++;
        end
        check("ready16_timeout", {31'd0, in_ready}, 32'd1);
    endtask

    task automatic txn16(input logic [15:0] a, input logic [15:0] b, input logic s,
                         input logic [2:0] lit, input int lat_def, input int lat_early,
                         input int stall);
        int n;
        int lat;
`ifdef CMP_EARLY_EXIT_EN
        lat = lat_early;
`else
        lat = lat_def;
`endif
        check("model_pin_result", {29'd0, ref_gle(a, b, s)}, {29'd0, lit});
        check("model_pin_latency", ref_lat(a, b), lat);
        wait_ready16();
        A = a; B = b; signed_mode = s; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        // Scrambled inputs after accept must not disturb the transaction.
        in_valid = 1'b1; A = 16'($urandom); B = 16'($urandom); signed_mode = ~s;
        n = 0;
        while (!out_valid && n < 64) begin
            @(posedge clk); #1; n++;
        end
        in_valid = 1'b0;
        check("latency", n, lat);
        check("result", {29'd0, g, l, e}, {29'd0, lit});
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            check("stall_hold", {27'd0, in_ready, out_valid, g, l, e}, {27'd0, 2'b01, lit});
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("release", {26'd0, in_ready, out_valid, busy, g, l, e}, 32'b100000);
    endtask

    task automatic txn12(input logic [11:0] a, input logic [11:0] b, input logic s,
                         input logic [2:0] lit, input int lat);
        int n = 0;
        while (!in_ready12 && n < 64) begin
            @(posedge clk); #1; n++;
        end
        A12 = a; B12 = b; sm12 = s; in_valid12 = 1'b1; out_ready12 = 1'b0;
        @(posedge clk); #1;
        in_valid12 = 1'b0;
        n = 0;
        while (!out_valid12 && n < 64) begin
            @(posedge clk); #1; n++;
        end
        check("latency12", n, lat);
        check("result12", {29'd0, g12, l12, e12}, {29'd0, lit});
        out_ready12 = 1'b1;
        @(posedge clk); #1;
        out_ready12 = 1'b0;
        check("release12", {26'd0, in_ready12, out_valid12, busy12, g12, l12, e12}, 32'b100000);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat12;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0; signed_mode = 1'b0;
        in_valid12 = 1'b0; out_ready12 = 1'b0; A12 = '0; B12 = '0; sm12 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset16", {26'd0, in_ready, out_valid, busy, g, l, e}, 32'b100000);
        check("reset12", {26'd0, in_ready12, out_valid12, busy12, g12, l12, e12}, 32'b100000);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // Directed vectors with hand-computed results and latencies.
        txn16(16'h8000, 16'h7FFF, 1'b1, 3'b010, 4, 1, 10);
        txn16(16'h8000, 16'h7FFF, 1'b0, 3'b100, 4, 1, 0);
        txn16(16'h1234, 16'h1234, 1'b1, 3'b001, 4, 4, 0);
        txn16(16'h1234, 16'h1234, 1'b0, 3'b001, 4, 4, 2);
        txn16(16'hF000, 16'h0000, 1'b0, 3'b100, 4, 1, 0);
        txn16(16'h0001, 16'h0002, 1'b0, 3'b010, 4, 4, 0);
        txn16(16'hFFFF, 16'h0001, 1'b1, 3'b010, 4, 1, 0);

        // Reset two chunks into RUN: transaction is dropped, a new one completes.
        wait_ready16();
        A = 16'h00F0; B = 16'h00E0; signed_mode = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("abort16", {26'd0, in_ready, out_valid, busy, g, l, e}, 32'b100000);
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check("abort16_no_result", {31'd0, out_valid}, 32'd0);
        end
        out_ready = 1'b0;
        txn16(16'h00F0, 16'h00E0, 1'b0, 3'b100, 4, 3, 0);

        // 12-bit / 3-bit-chunk instance, including a mid-RUN reset.
`ifdef CMP_EARLY_EXIT_EN
        lat12 = 1;
`else
        lat12 = 4;
`endif
        txn12(12'h800, 12'h7FF, 1'b1, 3'b010, lat12);
        A12 = 12'h123; B12 = 12'h124; sm12 = 1'b0; in_valid12 = 1'b1;
        @(posedge clk); #1;
        in_valid12 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("abort12", {26'd0, in_ready12, out_valid12, busy12, g12, l12, e12}, 32'b100000);
        txn12(12'h800, 12'h7FF, 1'b1, 3'b010, lat12);
        txn12(12'h800, 12'h7FF, 1'b0, 3'b100, lat12);

        // Randomized traffic against the model, with occasional resets.
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk); #1;
            in_valid    = 1'($urandom_range(0, 1));
            out_ready   = ($urandom_range(0, 3) != 0);
            signed_mode = 1'($urandom_range(0, 1));
            A           = 16'($urandom);
            case ($urandom_range(0, 3))
                0:       B = 16'($urandom);
                1:       B = A;
                2:       B = A ^ (16'd1 << $urandom_range(0, 15));
                default: B = {A[15:8], 8'($urandom)};
            endcase
            rst_n = ($urandom_range(0, 499) != 0);
        end
        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 20 && !in_ready; i++) begin
            @(posedge clk); #1;
        end
        check("drain_idle", {31'd0, in_ready}, 32'd1);

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_magnitude_comparator.md
# seq_magnitude_comparator

Parametrised, multi-cycle magnitude comparator. It compares two WIDTH-bit operands MSB-first, CHUNK bits per cycle, in signed (two's complement) or unsigned mode, selectable per transaction. Operands arrive on a valid/ready input handshake and the g/l/e result leaves on a valid/ready output handshake. It is the sequential, width-generic successor to the fixed 16-bit signed gate-level comparator, for datapaths where comparator area matters more than latency.

## Interface
Parameters:
- WIDTH, 16, operand width in bits; must be ≥ 2.
- CHUNK, 4, bits compared per cycle; WIDTH % CHUNK == 0 is required, otherwise elaboration fails. NCHUNK = WIDTH/CHUNK.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- in_valid  in  1  operand transaction valid.
- in_ready  out  1  block can accept an operand transaction.
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B.
- signed_mode  in  1  1 = two's-complement compare, 0 = unsigned.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- g  out  1  A > B.
- l  out  1  A < B.
- e  out  1  A == B.
- busy  out  1  high in RUN or DONE.

## Operation
- FSM states:
  - IDLE: in_ready=1.
  - RUN: compares one chunk per cycle.
  - DONE: out_valid=1.
- Accept: in IDLE, in_valid & in_ready at an edge latches A, B and signed_mode, clears the decided flag and sets chunk index idx=NCHUNK-1. Next state is RUN.
- Signed handling: in signed mode, the MSB of both latched operands is inverted (offset binary); the compare is unsigned thereafter. Unsigned mode leaves the operands unmodified.
- RUN, each edge: compare chunk idx of both operands.
  - If not yet decided and the chunks differ: decided=1, g/l set from the chunk magnitude.
  - Decrement idx.
  - After chunk 0 is processed: go to DONE; if still undecided, e=1.
- DONE: g/l/e held stable while out_valid=1.
  - out_valid & out_ready at an edge: go to IDLE and clear g/l/e.
  - No same-cycle turnaround: in_ready rises on the cycle after the output handshake.
- Invariant: when out_valid=1, exactly one of g, l, e is 1. When out_valid=0, g=l=e=0.
- Operands or signed_mode changing at the inputs during RUN/DONE has no effect.
- in_valid while not in IDLE is ignored; it is not queued.

## Timing
- Reset values: in_ready=1, out_valid=0, g=l=e=0, busy=0; state IDLE.
- Reset is valid in any state. rst_n low at an edge aborts a RUN or DONE transaction and drops its result.
- Latency, counted as edges from the accept edge to the edge that raises out_valid: NCHUNK, independent of data (default build).
- Throughput: one transaction per NCHUNK+2 cycles with out_ready held high.
- out_ready low in DONE stalls indefinitely with outputs stable.

## Configuration
- CMP_EARLY_EXIT_EN defined: RUN goes to DONE on the edge that finds the first differing chunk. Latency becomes j+1, where j is the 0-based chunk position counted from the MSB. Equal operands still take NCHUNK.
- CMP_EARLY_EXIT_EN undefined: always NCHUNK cycles of RUN. Latency is constant, which the timing-predictable datapath relies on.
- Results are identical in both builds; only latency differs.

## Test plan
- WIDTH=16, CHUNK=4, signed_mode=1, A=0x8000, B=0x7FFF -> l=1, g=e=0; out_valid 4 edges after accept (default build).
- Same operands with signed_mode=0 -> g=1, l=e=0.
- A=B=0x1234, both modes -> e=1 after 4 edges, in both builds.
- A=0xF000, B=0x0000, unsigned -> g=1; latency 1 with CMP_EARLY_EXIT_EN, 4 without. A=0x0001, B=0x0002 -> l=1, latency 4 in both builds.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> g/l/e and out_valid stable and in_ready=0 throughout. Release -> IDLE next edge, outputs 0, in_ready=1.
- Reset mid-RUN: rst_n=0 for 1 edge after 2 chunks -> all outputs at reset values, no out_valid for the aborted transaction. A new transaction then completes correctly. Repeat with WIDTH=12, CHUNK=3: A=0x800, B=0x7FF signed -> l=1, latency 4.
